mem_b_arbiter: RTL

MEM_B_ARBITER -- requirements
Module: mem_b_arbiter

---
 rtl/mem_b_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_b_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_b_arbiter
// Purpose  : Shares data-memory port B between VGA scanout reads and
//            periodic GIO pin samples written to a fixed memory word.
//            VGA normally has priority. A pending GIO write wins once it has
//            waited STARVE_MAX cycles.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            vga_req/vga_addr/vga_ack   - scanout read request handshake
//            vga_data/vga_valid         - scanout read return
//            GIO_pins                   - asynchronous pin inputs
//            addr_b/data_b/we_b/q_b     - memory port B (1-cycle read latency)
//            gio_wr_cnt                 - count of GIO writes performed
// Revision : 1.0 - initial release
// ============================================================================
module mem_b_arbiter #(
    parameter logic [15:0] SAMPLE_DIV = 16'd50000,
    parameter logic [7:0]  STARVE_MAX = 8'd8,
    parameter logic [15:0] GIO_ADDR   = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_req,
    input  logic [15:0] vga_addr,
    output logic        vga_ack,
    output logic [15:0] vga_data,
    output logic        vga_valid,
    input  logic [7:0]  GIO_pins,
    output logic [15:0] addr_b,
    output logic [15:0] data_b,
    output logic        we_b,
    input  logic [15:0] q_b,
    output logic [7:0]  gio_wr_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD      = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] WR      = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  gio_meta_q, gio_sync_q;
    logic [15:0] div_q;
    logic        pending_q;
    logic [7:0]  pend_val_q;
    logic [7:0]  last_written_q;
    logic        first_q;
    logic [7:0]  starve_q;
    logic [15:0] addr_b_q, data_b_q, vga_data_q;
    logic        we_b_q, vga_ack_q, vga_valid_q;
    logic [7:0]  gio_wr_cnt_q;

    logic        w_tick;
    logic [7:0]  w_wr_val;
    logic [7:0]  w_cmp_val;
    logic        w_first;
    logic        w_sample;

    assign w_tick = (div_q == (SAMPLE_DIV - 16'd1));

    // The byte actually being written during WR is the registered data_b,
    // which may differ from pend_val_q if a tick landed on the WR entry edge.
    assign w_wr_val  = data_b_q[7:0];
    assign w_cmp_val = (state_q == WR) ? w_wr_val : last_written_q;
    assign w_first   = first_q && (state_q != WR);
    assign w_sample  = w_tick && (w_first || (gio_sync_q != w_cmp_val));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RD_DATA: begin
                if (pending_q && (starve_q >= STARVE_MAX)) begin
                    state_d = WR;
                end else if (vga_req) begin
                    state_d = RD;
                end else if (pending_q) begin
                    state_d = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            RD:      state_d = RD_DATA;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            gio_meta_q     <= 8'h00;
            gio_sync_q     <= 8'h00;
            div_q          <= 16'h0000;
            pending_q      <= 1'b0;
            pend_val_q     <= 8'h00;
            last_written_q <= 8'h00;
            first_q        <= 1'b1;
            starve_q       <= 8'h00;
            addr_b_q       <= 16'h0000;
            data_b_q       <= 16'h0000;
            we_b_q         <= 1'b0;
            vga_ack_q      <= 1'b0;
            vga_data_q     <= 16'h0000;
            vga_valid_q    <= 1'b0;
            gio_wr_cnt_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            gio_meta_q <= GIO_pins;
            gio_sync_q <= gio_meta_q;
            div_q      <= w_tick ? 16'h0000 : div_q + 16'd1;

            // Port B outputs are registered for the state being entered.
            addr_b_q    <= 16'h0000;
            data_b_q    <= 16'h0000;
            we_b_q      <= 1'b0;
            vga_ack_q   <= 1'b0;
            vga_valid_q <= (state_q == RD_DATA);
            if (state_d == RD) begin
                addr_b_q  <= vga_addr;
                vga_ack_q <= 1'b1;
            end else if (state_d == WR) begin
                addr_b_q <= GIO_ADDR;
                data_b_q <= {8'h00, pend_val_q};
                we_b_q   <= 1'b1;
            end

            if (state_q == RD_DATA) begin
                vga_data_q <= q_b;
            end

            if (state_q == WR) begin
                last_written_q <= w_wr_val;
                first_q        <= 1'b0;
                gio_wr_cnt_q   <= gio_wr_cnt_q + 8'd1;
                // Keep pending if a newer sample replaced the value in flight.
                if (pend_val_q == w_wr_val) begin
                    pending_q <= 1'b0;
                end
            end

            // A fresh sample overrides the WR clear above (latest wins).
            if (w_sample) begin
                pending_q  <= 1'b1;
                pend_val_q <= gio_sync_q;
            end

            if (state_q == WR) begin
                starve_q <= 8'h00;
            end else if (pending_q && (starve_q != 8'hFF)) begin
                starve_q <= starve_q + 8'd1;
            end
        end
    end

    assign addr_b     = addr_b_q;
    assign data_b     = data_b_q;
    assign we_b       = we_b_q;
    assign vga_ack    = vga_ack_q;
    assign vga_data   = vga_data_q;
    assign vga_valid  = vga_valid_q;
    assign gio_wr_cnt = gio_wr_cnt_q;

endmodule
`default_nettype wire
